fifo_word_packer: RTL and testbench

- Read-domain consumer of the async FIFO. Drains its show-ahead byte read port and packs DWIDTH-bit entries into PACK-entry words.
- Presents the packed words on a valid/ready stream to the downstream processing stage.
- Tags the final word of each fixed-length frame with m_last and counts completed frames.

---
 rtl/fifo_word_packer_pkg.sv | 28 ++
 rtl/fifo_word_packer_if.sv | 29 ++
 rtl/fifo_word_packer.sv | 165 ++++++++++++++++
 tb/tb_fifo_word_packer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared types and constants for the FIFO word packer.
package fifo_word_packer_pkg;

  // Packer control state: FILL drains the FIFO, HOLD parks a full accumulator
  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Default configuration
  localparam int unsigned DWIDTH_DEF      = 8;
  localparam int unsigned PACK_DEF        = 4;
  localparam int unsigned FRAME_WORDS_DEF = 16;

  // Derived widths for the default configuration
  localparam int unsigned LANE_W = $clog2(PACK_DEF);
  localparam int unsigned WORD_W = DWIDTH_DEF * PACK_DEF;
  localparam int unsigned CNT_W  = $clog2(FRAME_WORDS_DEF);

  // Completed-frame counter width
  localparam int unsigned FRAME_CNT_W = 16;

  // Counter width that stays at least one bit wide for n <= 1
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read port plus packed-word stream of the FIFO word packer.
// master: the packer; slave: FIFO/downstream side.
interface fifo_word_packer_if #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned PACK   = 4
);
  import fifo_word_packer_pkg::*;

  logic [DWIDTH-1:0]        fifo_rdata;
  logic                     fifo_rempty;
  logic                     fifo_r_en;
  logic [DWIDTH*PACK-1:0]   m_data;
  logic [$clog2(PACK):0]    m_bytes;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;
  logic [FRAME_CNT_W-1:0]   frame_cnt;

  modport master (
    input  fifo_rdata, fifo_rempty, m_ready,
    output fifo_r_en, m_data, m_bytes, m_valid, m_last, frame_cnt
  );

  modport slave (
    output fifo_rdata, fifo_rempty, m_ready,
    input  fifo_r_en, m_data, m_bytes, m_valid, m_last, frame_cnt
  );

endinterface

// File: rtl/fifo_word_packer.sv
// FIFO word packer: pops DWIDTH-bit entries from a show-ahead FIFO read
// port, packs PACK of them little-endian into one word and streams the
// words out on valid/ready, tagging the last word of each frame.
// Optional: FIFO_WORD_PACKER_TIMEOUT_EN flushes a partial word after
// TIMEOUT idle cycles.
module fifo_word_packer
  import fifo_word_packer_pkg::*;
#(
  parameter int unsigned DWIDTH      = DWIDTH_DEF,
  parameter int unsigned PACK        = PACK_DEF,
  parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic                clk,
  input  logic                rst,
  fifo_word_packer_if.master  bus
);

  localparam int unsigned LW = $clog2(PACK);
  localparam int unsigned WW = DWIDTH * PACK;
  localparam int unsigned CW = cnt_width(FRAME_WORDS);
  localparam int unsigned BW = LW + 1;

  pack_state_t            state_q, state_d;
  logic [LW-1:0]          lane_q;
  logic [WW-1:0]          acc_q;
  logic [WW-1:0]          acc_ins;
  logic [CW-1:0]          wcnt_q;

  logic                   m_valid_q;
  logic [WW-1:0]          m_data_q;
  logic [BW-1:0]          m_bytes_q;
  logic                   m_last_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;

  logic                   pop;
  logic                   out_free;
  logic                   load;
  logic                   flush;
  logic                   timeout_hit;
  logic [WW-1:0]          word_d;
  logic [BW-1:0]          bytes_d;

  assign out_free = !m_valid_q || bus.m_ready;

`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_q;

  assign timeout_hit = (idle_q >= IW'(TIMEOUT)) && (lane_q != '0);

  // Idle counter: cycles spent starved with a partially filled word
  always_ff @(posedge clk) begin
    if (rst || pop || load) begin
      idle_q <= '0;
    end else if (state_q == FILL && lane_q != '0 && bus.fifo_rempty && !timeout_hit) begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0 && (TIMEOUT != 0);
`endif

  // Current FIFO head merged into the accumulator at the active lane
  always_comb begin
    acc_ins = acc_q;
    acc_ins[lane_q*DWIDTH +: DWIDTH] = bus.fifo_rdata;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, pop request and output-register load decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    flush   = 1'b0;
    word_d  = acc_ins;
    bytes_d = BW'(PACK);
    case (state_q)
      FILL: begin
        pop = !bus.fifo_rempty && !rst;
        if (pop && lane_q == LW'(PACK - 1)) begin
          if (out_free) begin
            load = 1'b1;
          end else begin
            state_d = HOLD;
          end
        end else if (!pop && timeout_hit && out_free) begin
          // Partial word: unused upper lanes are already zero in acc_q
          load    = 1'b1;
          flush   = 1'b1;
          word_d  = acc_q;
          bytes_d = {1'b0, lane_q};
        end
      end
      HOLD: begin
        word_d = acc_q;
        if (out_free) begin
          load    = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Accumulator and lane counter; a load always leaves an empty accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      lane_q <= '0;
    end else if (load) begin
      acc_q  <= '0;
      lane_q <= '0;
    end else if (pop) begin
      acc_q  <= acc_ins;
      lane_q <= lane_q + 1'b1;
    end
  end

  // Output register, frame word counter and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_bytes_q   <= '0;
      m_last_q    <= 1'b0;
      wcnt_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= word_d;
        m_bytes_q <= bytes_d;
        m_last_q  <= flush || (wcnt_q == CW'(FRAME_WORDS - 1));
        if (flush || wcnt_q == CW'(FRAME_WORDS - 1)) begin
          wcnt_q <= '0;
        end else begin
          wcnt_q <= wcnt_q + 1'b1;
        end
      end else if (m_valid_q && bus.m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (m_valid_q && bus.m_ready && m_last_q) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign bus.fifo_r_en = pop;
  assign bus.m_valid   = m_valid_q;
  assign bus.m_data    = m_data_q;
  assign bus.m_bytes   = m_bytes_q;
  assign bus.m_last    = m_last_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Testbench for fifo_word_packer: FIFO model on the read side, scoreboard
// of expected words on the output side, vector table plus corner sequences.
// Build with FIFO_WORD_PACKER_TIMEOUT_EN to cover the partial-flush path.
module tb_fifo_word_packer;
  import fifo_word_packer_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned PK = 4;
  localparam int unsigned FW = 16;
  localparam int unsigned TO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_word_packer_if #(.DWIDTH(DW), .PACK(PK)) bus ();

  fifo_word_packer #(
    .DWIDTH(DW), .PACK(PK), .FRAME_WORDS(FW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
  } exp_t;

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    int unsigned gap;
    logic [31:0] exp_data;
  } vec_t;

  logic [7:0]  src_q[$];
  exp_t        exp_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic        drv_rst = 1'b1;
  logic        drv_ready = 1'b1;
  int unsigned gap = 0;
  int unsigned cyc = 0;

  int unsigned m_lane = 0;
  logic [31:0] m_acc = '0;
  int unsigned m_wcnt = 0;

  int unsigned pops = 0;
  int unsigned hs_cnt = 0;
  int unsigned hs_cyc = 0;
  int unsigned last_pop_cyc = 0;
  int unsigned valid_rise_cyc = 0;
  int unsigned ren_stall = 0;
  logic        prev_valid = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_data = '0;
  logic [31:0] last_data = '0;
  logic [2:0]  last_bytes = '0;
  logic        last_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_lane = 0;
    m_acc  = '0;
    m_wcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic [7:0] b);
    exp_t e;
    m_acc[m_lane*8 +: 8] = b;
    m_lane++;
    if (m_lane == PK) begin
      e.data  = m_acc;
      e.bytes = 3'(PK);
      e.last  = (m_wcnt == FW - 1);
      exp_q.push_back(e);
      m_wcnt = (m_wcnt == FW - 1) ? 0 : m_wcnt + 1;
      m_lane = 0;
      m_acc  = '0;
    end
  endtask

  task automatic handshake();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_word", bus.m_data, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check("m_data", bus.m_data, e.data);
      check("m_bytes", bus.m_bytes, e.bytes);
      check("m_last", bus.m_last, e.last);
    end
    last_data  = bus.m_data;
    last_bytes = bus.m_bytes;
    last_last  = bus.m_last;
    hs_cnt++;
    hs_cyc = cyc;
  endtask

  // One clock: drive at negedge, observe #1 later, then wait for posedge
  task automatic cycle();
    logic gate;
    @(negedge clk);
    gate = (gap != 0) && ((cyc % (gap + 1)) != 0);
    rst = drv_rst;
    bus.m_ready = drv_ready;
    bus.fifo_rempty = gate || (src_q.size() == 0);
    bus.fifo_rdata = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    if (hold_pending) begin
      check("hold_valid", bus.m_valid, 1'b1);
      check("hold_data", bus.m_data, held_data);
    end
    hold_pending = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      if (bus.fifo_r_en) begin
        model_push(src_q.pop_front());
        pops++;
        last_pop_cyc = cyc;
      end else if (!bus.fifo_rempty) begin
        ren_stall++;
      end
      if (bus.m_valid && !prev_valid) valid_rise_cyc = cyc;
      if (bus.m_valid && bus.m_ready) begin
        handshake();
      end else if (bus.m_valid) begin
        hold_pending = 1'b1;
        held_data = bus.m_data;
      end
    end
    prev_valid = bus.m_valid;
    cyc++;
    @(posedge clk);
  endtask

  task automatic wait_hs(input int unsigned target, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (hs_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check(name, (hs_cnt >= target), 1'b1);
  endtask

  task automatic wait_pops(input int unsigned target, input int unsigned budget, input string name);
    int unsigned n = 0;
    while (pops < target && n < budget) begin
      cycle();
      n++;
    end
    check(name, (pops >= target), 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_fifo_r_en"}, bus.fifo_r_en, 1'b0);
    check({tag, "_m_valid"}, bus.m_valid, 1'b0);
    check({tag, "_m_last"}, bus.m_last, 1'b0);
    check({tag, "_m_data"}, bus.m_data, '0);
    check({tag, "_m_bytes"}, bus.m_bytes, '0);
    check({tag, "_frame_cnt"}, bus.frame_cnt, '0);
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    cycle();
    drv_rst = 1'b0;
  endtask

  vec_t vecs[4];
  int unsigned hs0, p0;

  initial begin
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 0, 32'h4433_2211};
    vecs[1] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3, 1, 32'hD3C2_B1A0};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 1, 32'h0403_0201};
    vecs[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 2, 32'h00FF_00FF};

    bus.m_ready = 1'b1;
    bus.fifo_rempty = 1'b1;
    bus.fifo_rdata = '0;

    // Reset state
    drv_rst = 1'b1;
    repeat (2) cycle();
    #1 check_zero("reset");
    drv_rst = 1'b0;

    // Vector table: single words with varying empty gaps
    for (int i = 0; i < 4; i++) begin
      hs0 = hs_cnt;
      p0 = pops;
      gap = vecs[i].gap;
      src_q.push_back(vecs[i].b0);
      src_q.push_back(vecs[i].b1);
      src_q.push_back(vecs[i].b2);
      src_q.push_back(vecs[i].b3);
      wait_hs(hs0 + 1, 60, $sformatf("vec%0d_hs_timeout", i));
      check($sformatf("vec%0d_data", i), last_data, vecs[i].exp_data);
      check($sformatf("vec%0d_bytes", i), last_bytes, 3'd4);
      check($sformatf("vec%0d_pops", i), pops - p0, 4);
      if (i == 0) check("vec0_latency", valid_rise_cyc, last_pop_cyc + 1);
    end
    gap = 0;

    // Continuous stream of one full frame
    do_reset();
    hs0 = hs_cnt;
    ren_stall = 0;
    for (int i = 0; i < 64; i++) src_q.push_back(8'(i));
    wait_hs(hs0 + 16, 200, "stream_hs_timeout");
    check("stream_last_data", last_data, 32'h3F3E_3D3C);
    check("stream_last_flag", last_last, 1'b1);
    check("stream_ren_stall", ren_stall, 0);
    #1 check("stream_frame_cnt", bus.frame_cnt, 16'd1);

    // Downstream stall: first word held, second parked in HOLD
    drv_ready = 1'b0;
    hs0 = hs_cnt;
    p0 = pops;
    for (int i = 0; i < 12; i++) src_q.push_back(8'(8'h80 + i));
    repeat (20) cycle();
    #1;
    check("stall_pops", pops - p0, 8);
    check("stall_fifo_r_en", bus.fifo_r_en, 1'b0);
    check("stall_m_valid", bus.m_valid, 1'b1);
    check("stall_m_data", bus.m_data, 32'h8382_8180);
    drv_ready = 1'b1;
    wait_hs(hs0 + 3, 40, "stall_hs_timeout");
    check("stall_total_pops", pops - p0, 12);
    check("stall_final_data", last_data, 32'h8B8A_8988);

    // Reset in the middle of a word, then a clean frame from scratch
    p0 = pops;
    src_q.push_back(8'h55);
    src_q.push_back(8'h66);
    wait_pops(p0 + 2, 20, "midrst_pop_timeout");
    do_reset();
    #1 check_zero("midrst");
    hs0 = hs_cnt;
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h11 + i));
    wait_hs(hs0 + 1, 40, "midrst_hs_timeout");
    check("midrst_word", last_data, 32'h1413_1211);
    for (int i = 0; i < 60; i++) src_q.push_back(8'(8'h40 + i));
    wait_hs(hs0 + 16, 200, "midrst_frame_timeout");
    check("midrst_frame_last", last_last, 1'b1);
    #1 check("midrst_frame_cnt", bus.frame_cnt, 16'd1);

    // Partial word left in the accumulator
    p0 = pops;
    hs0 = hs_cnt;
    src_q.push_back(8'hAA);
    src_q.push_back(8'hBB);
    src_q.push_back(8'hCC);
    wait_pops(p0 + 3, 20, "partial_pop_timeout");
`ifdef FIFO_WORD_PACKER_TIMEOUT_EN
    begin
      exp_t e;
      e.data  = 32'h00CC_BBAA;
      e.bytes = 3'd3;
      e.last  = 1'b1;
      exp_q.push_back(e);
      m_lane = 0;
      m_acc  = '0;
      m_wcnt = 0;
    end
    wait_hs(hs0 + 1, 100, "timeout_hs_timeout");
    check("timeout_data", last_data, 32'h00CC_BBAA);
    check("timeout_bytes", last_bytes, 3'd3);
    check("timeout_last", last_last, 1'b1);
    check("timeout_delay_ok", (hs_cyc - last_pop_cyc >= TO) && (hs_cyc - last_pop_cyc <= TO + 4), 1'b1);
    #1 check("timeout_frame_cnt", bus.frame_cnt, 16'd2);
`else
    repeat (100) cycle();
    check("partial_no_word", hs_cnt - hs0, 0);
    check("partial_m_valid", bus.m_valid, 1'b0);
    do_reset();
`endif

    cycle();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time limit
  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1);
  end

endmodule
